// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Merges the three writeback sources of the dual-issue core onto the two
// write ports of the register file:
//   - ALU1 owns write port 1 and ALU2 owns write port 2 whenever they carry
//     an active result (valid and rd != x0). These results cannot stall.
//   - Load returns arrive on a valid/ready handshake. They are parked in a
//     small in-order circular buffer and drained into whichever port slots
//     the ALUs leave free that cycle.
//   - A buffered load is older than any ALU result presented while it sits
//     in the buffer. A younger ALU write to the same register therefore
//     makes the load stale, so the load is killed: it still drains in order,
//     but it drives a write enable of 0.
//   - pending_mask exposes the destinations of live buffered loads for the
//     hazard logic.
//
// Ports:
//   clk                         rising-edge clock
//   rst                         asynchronous reset, active low
//   alu1_valid/rd/data          ALU1 result (fixed latency)
//   alu2_valid/rd/data          ALU2 result (fixed latency)
//   ld_valid/ld_rd/ld_data      load return, ld_ready is the buffer's ready
//   reg_write/regd/write_data   register file write port 1 (registered)
//   reg_write2/regd2/write_data2 register file write port 2 (registered)
//   pending_mask                bit r set while a live buffered load targets r
//   buf_count                   occupied buffer entries
// ---------------------------------------------------------------------------
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu1_valid,
  input  logic [4:0]             alu1_rd,
  input  logic [31:0]            alu1_data,
  input  logic                   alu2_valid,
  input  logic [4:0]             alu2_rd,
  input  logic [31:0]            alu2_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [4:0]             ld_rd,
  input  logic [31:0]            ld_data,
  output logic                   reg_write,
  output logic [4:0]             regd,
  output logic [31:0]            write_data,
  output logic                   reg_write2,
  output logic [4:0]             regd2,
  output logic [31:0]            write_data2,
  output logic [31:0]            pending_mask,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // True when an active ALU result in the current cycle targets rd.
  function automatic logic kill_hit(input logic [4:0] rd,
                                    input logic       a1,
                                    input logic [4:0] r1,
                                    input logic       a2,
                                    input logic [4:0] r2);
    return (a1 && (r1 == rd)) || (a2 && (r2 == rd));
  endfunction

  // Buffer state. live_q is cleared on pop, so it alone marks entries that
  // will still write; occupancy is tracked by head/tail/count.
  logic [4:0]    rd_q   [DEPTH];
  logic [4:0]    rd_d   [DEPTH];
  logic          live_q [DEPTH];
  logic          live_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Registered write ports.
  logic          reg_write_q,   reg_write_d;
  logic [4:0]    regd_q,        regd_d;
  logic [31:0]   write_data_q,  write_data_d;
  logic          reg_write2_q,  reg_write2_d;
  logic [4:0]    regd2_q,       regd2_d;
  logic [31:0]   write_data2_q, write_data2_d;

  logic          alu1_act, alu2_act;
  logic          accept, enq;
  logic          p1_pop, p2_pop;
  logic [PW-1:0] idx1, idx2;
  logic          p1_live, p2_live;
  logic [CW-1:0] n_pop;
  logic          ld_live;

  // ---- Stage 0: classify sources, pick drain slots --------------------------
  // rd == x0 never writes, so such results are treated as absent.
  assign alu1_act = alu1_valid && (alu1_rd != 5'd0);
  assign alu2_act = alu2_valid && (alu2_rd != 5'd0);

  // Ready comes from registered occupancy only; a pop this cycle does not
  // open a slot until the next cycle. Held low while reset is asserted.
  assign ld_ready = rst && (count_q < CW'(DEPTH));
  assign accept   = ld_valid && ld_ready;
  // A load to x0 completes the handshake but is dropped.
  assign enq      = accept && (ld_rd != 5'd0);
  // Loads are older than the ALU results of the cycle they arrive in.
  assign ld_live  = !kill_hit(ld_rd, alu1_act, alu1_rd, alu2_act, alu2_rd);

  // Free slots are filled in port order; the head always lands on the lower
  // port so program order is kept between the two drained entries.
  assign p1_pop  = !alu1_act && (count_q != '0);
  assign p2_pop  = !alu2_act && (count_q > CW'(p1_pop));
  assign idx1    = head_q;
  assign idx2    = head_q + PW'(p1_pop);
  assign n_pop   = CW'(p1_pop) + CW'(p2_pop);

  // An entry drained in the same cycle as a matching ALU write is already
  // stale and must not reach the register file.
  assign p1_live = p1_pop && live_q[idx1] &&
                   !kill_hit(rd_q[idx1], alu1_act, alu1_rd, alu2_act, alu2_rd);
  assign p2_live = p2_pop && live_q[idx2] &&
                   !kill_hit(rd_q[idx2], alu1_act, alu1_rd, alu2_act, alu2_rd);

  always_comb begin
    head_d  = head_q + PW'(n_pop);
    tail_d  = enq ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enq) - n_pop;

    for (int i = 0; i < DEPTH; i++) begin
      rd_d[i]   = rd_q[i];
      live_d[i] = live_q[i] &&
                  !kill_hit(rd_q[i], alu1_act, alu1_rd, alu2_act, alu2_rd);
    end
    if (p1_pop) live_d[idx1] = 1'b0;
    if (p2_pop) live_d[idx2] = 1'b0;
    // The tail slot is never one of the popped slots: enqueue requires
    // count < DEPTH, so the tail points past every occupied entry.
    if (enq) begin
      rd_d[tail_q]   = ld_rd;
      live_d[tail_q] = ld_live;
    end
  end

  always_comb begin
    reg_write_d   = 1'b0;
    regd_d        = regd_q;
    write_data_d  = write_data_q;
    reg_write2_d  = 1'b0;
    regd2_d       = regd2_q;
    write_data2_d = write_data2_q;

    if (alu1_act) begin
      reg_write_d  = 1'b1;
      regd_d       = alu1_rd;
      write_data_d = alu1_data;
    end else if (p1_live) begin
      reg_write_d  = 1'b1;
      regd_d       = rd_q[idx1];
      write_data_d = data_q[idx1];
    end

    if (alu2_act) begin
      reg_write2_d  = 1'b1;
      regd2_d       = alu2_rd;
      write_data2_d = alu2_data;
    end else if (p2_live) begin
      reg_write2_d  = 1'b1;
      regd2_d       = rd_q[idx2];
      write_data2_d = data_q[idx2];
    end
  end

  // ---- Stage 1: registered buffer state and write ports ---------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        live_q[i] <= 1'b0;
      end
      reg_write_q   <= 1'b0;
      regd_q        <= 5'd0;
      write_data_q  <= 32'd0;
      reg_write2_q  <= 1'b0;
      regd2_q       <= 5'd0;
      write_data2_q <= 32'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        live_q[i] <= live_d[i];
      end
      reg_write_q   <= reg_write_d;
      regd_q        <= regd_d;
      write_data_q  <= write_data_d;
      reg_write2_q  <= reg_write2_d;
      regd2_q       <= regd2_d;
      write_data2_q <= write_data2_d;
    end
  end

  // Payload storage carries no reset: an entry's data is only read while
  // live_q marks it valid.
  always_ff @(posedge clk) begin
    if (enq) data_q[tail_q] <= ld_data;
  end

  always_comb begin
    pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask[rd_q[i]] = 1'b1;
    end
  end

  assign buf_count   = count_q;
  assign reg_write   = reg_write_q;
  assign regd        = regd_q;
  assign write_data  = write_data_q;
  assign reg_write2  = reg_write2_q;
  assign regd2       = regd2_q;
  assign write_data2 = write_data2_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        alu1_valid, alu2_valid, ld_valid;
  logic [4:0]  alu1_rd, alu2_rd, ld_rd;
  logic [31:0] alu1_data, alu2_data, ld_data;
  logic        ld_ready;
  logic        reg_write, reg_write2;
  logic [4:0]  regd, regd2;
  logic [31:0] write_data, write_data2;
  logic [31:0] pending_mask;
  logic [2:0]  buf_count;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_arbiter #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu1_valid   (alu1_valid),
    .alu1_rd      (alu1_rd),
    .alu1_data    (alu1_data),
    .alu2_valid   (alu2_valid),
    .alu2_rd      (alu2_rd),
    .alu2_data    (alu2_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .reg_write    (reg_write),
    .regd         (regd),
    .write_data   (write_data),
    .reg_write2   (reg_write2),
    .regd2        (regd2),
    .write_data2  (write_data2),
    .pending_mask (pending_mask),
    .buf_count    (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         input logic v2, input logic [4:0] r2, input logic [31:0] d2);
    alu1_valid = v1; alu1_rd = r1; alu1_data = d1;
    alu2_valid = v2; alu2_rd = r2; alu2_data = d2;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] r, input logic [31:0] d);
    ld_valid = v; ld_rd = r; ld_data = d;
  endtask

  task automatic chk_p1(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we1"}, 32'(reg_write), 32'(we));
    chk({tag, ".rd1"}, 32'(regd), 32'(rd));
    chk({tag, ".wd1"}, write_data, d);
  endtask

  task automatic chk_p2(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we2"}, 32'(reg_write2), 32'(we));
    chk({tag, ".rd2"}, 32'(regd2), 32'(rd));
    chk({tag, ".wd2"}, write_data2, d);
  endtask

  initial begin
    rst = 1'b0;
    set_alu(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0);

    // Reset then idle
    tick(); tick();
    chk_p1("rst", 1'b0, 5'd0, 32'd0);
    chk_p2("rst", 1'b0, 5'd0, 32'd0);
    chk("rst.ready", 32'(ld_ready), 32'd0);
    chk("rst.count", 32'(buf_count), 32'd0);
    chk("rst.pend",  pending_mask, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel.ready", 32'(ld_ready), 32'd1);
    chk("rel.count", 32'(buf_count), 32'd0);

    // ALU pass-through
    set_alu(1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'h22);
    tick();
    chk_p1("pass", 1'b1, 5'd5, 32'h11);
    chk_p2("pass", 1'b1, 5'd7, 32'h22);
    set_alu(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk_p1("idle", 1'b0, 5'd5, 32'h11);
    chk_p2("idle", 1'b0, 5'd7, 32'h22);

    // Two loads to rd=3 buffered behind busy ALUs, then drained together
    set_alu(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'h2);
    set_ld(1'b1, 5'd3, 32'hA);
    tick();
    chk("ld1.count", 32'(buf_count), 32'd1);
    chk("ld1.pend",  pending_mask, 32'h8);
    set_ld(1'b1, 5'd3, 32'hB);
    tick();
    chk("ld2.count", 32'(buf_count), 32'd2);
    chk("ld2.pend",  pending_mask, 32'h8);
    set_alu(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0);
    tick();
    chk_p1("drain2", 1'b1, 5'd3, 32'hA);
    chk_p2("drain2", 1'b1, 5'd3, 32'hB);
    chk("drain2.count", 32'(buf_count), 32'd0);
    chk("drain2.pend",  pending_mask, 32'd0);

    // Fill to DEPTH with both ALUs busy, then backpressure
    set_alu(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'h2);
    for (int i = 0; i < 4; i++) begin
      set_ld(1'b1, 5'(10 + i), 32'h100 + 32'(i));
      tick();
    end
    chk("fill.count", 32'(buf_count), 32'd4);
    chk("fill.ready", 32'(ld_ready), 32'd0);
    chk("fill.pend",  pending_mask, 32'h3C00);
    chk_p1("fill", 1'b1, 5'd20, 32'h1);
    set_ld(1'b1, 5'd14, 32'h104);
    tick();
    chk("held.count", 32'(buf_count), 32'd4);
    chk("held.ready", 32'(ld_ready), 32'd0);
    // ALU1 idles: one pop per cycle on port 1
    set_alu(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h2);
    tick();
    chk_p1("pop0", 1'b1, 5'd10, 32'h100);
    chk_p2("pop0", 1'b1, 5'd21, 32'h2);
    chk("pop0.count", 32'(buf_count), 32'd3);
    chk("pop0.ready", 32'(ld_ready), 32'd1);
    chk("pop0.pend",  pending_mask, 32'h3800);
    tick();
    chk_p1("pop1", 1'b1, 5'd11, 32'h101);
    chk("pop1.count", 32'(buf_count), 32'd3);
    chk("pop1.pend",  pending_mask, 32'h7000);
    set_ld(1'b0, 5'd0, 32'd0);
    tick();
    chk_p1("pop2", 1'b1, 5'd12, 32'h102);
    chk("pop2.count", 32'(buf_count), 32'd2);
    tick();
    chk_p1("pop3", 1'b1, 5'd13, 32'h103);
    chk("pop3.pend",  pending_mask, 32'h4000);
    tick();
    chk_p1("pop4", 1'b1, 5'd14, 32'h104);
    chk("pop4.count", 32'(buf_count), 32'd0);
    chk("pop4.pend",  pending_mask, 32'd0);

    // Kill of a resident entry by a younger ALU2 write
    set_alu(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'h2);
    set_ld(1'b1, 5'd9, 32'h55);
    tick();
    chk("kill.pend0", pending_mask, 32'h200);
    set_ld(1'b0, 5'd0, 32'd0);
    set_alu(1'b1, 5'd20, 32'h1, 1'b1, 5'd9, 32'h77);
    tick();
    chk_p2("kill.alu", 1'b1, 5'd9, 32'h77);
    chk("kill.pend1", pending_mask, 32'd0);
    chk("kill.count", 32'(buf_count), 32'd1);
    set_alu(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk_p1("kill.drain", 1'b0, 5'd20, 32'h1);
    chk_p2("kill.drain", 1'b0, 5'd9, 32'h77);
    chk("kill.count2", 32'(buf_count), 32'd0);

    // Kill of an entry in the very cycle it drains
    set_alu(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'h2);
    set_ld(1'b1, 5'd9, 32'h66);
    tick();
    set_ld(1'b0, 5'd0, 32'd0);
    set_alu(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h88);
    tick();
    chk_p1("kdrain", 1'b0, 5'd20, 32'h1);
    chk_p2("kdrain", 1'b1, 5'd9, 32'h88);
    chk("kdrain.count", 32'(buf_count), 32'd0);

    // Load enqueued already killed by a same-cycle ALU write
    set_alu(1'b1, 5'd20, 32'h1, 1'b1, 5'd9, 32'h99);
    set_ld(1'b1, 5'd9, 32'h44);
    tick();
    chk("kenq.count", 32'(buf_count), 32'd1);
    chk("kenq.pend",  pending_mask, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0);
    set_alu(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    chk_p1("kenq.drain", 1'b0, 5'd20, 32'h1);
    chk("kenq.count2", 32'(buf_count), 32'd0);

    // x0 handling: alu1 rd=0 leaves port 1 free; load to x0 is dropped
    set_alu(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'h2);
    set_ld(1'b1, 5'd15, 32'h99);
    tick();
    set_alu(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd21, 32'h3);
    set_ld(1'b1, 5'd0, 32'hBEEF);
    tick();
    chk_p1("x0", 1'b1, 5'd15, 32'h99);
    chk_p2("x0", 1'b1, 5'd21, 32'h3);
    chk("x0.count", 32'(buf_count), 32'd0);
    chk("x0.pend",  pending_mask, 32'd0);

    // Reset mid-operation drops buffered loads
    set_alu(1'b1, 5'd20, 32'h1, 1'b1, 5'd21, 32'h2);
    set_ld(1'b1, 5'd4, 32'h123);
    tick(); tick();
    chk("mrst.count0", 32'(buf_count), 32'd2);
    rst = 1'b0;
    #1;
    chk("mrst.count", 32'(buf_count), 32'd0);
    chk("mrst.pend",  pending_mask, 32'd0);
    chk("mrst.ready", 32'(ld_ready), 32'd0);
    chk_p1("mrst", 1'b0, 5'd0, 32'd0);
    set_alu(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_ld(1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk_p1("mrst.after", 1'b0, 5'd0, 32'd0);
    chk_p2("mrst.after", 1'b0, 5'd0, 32'd0);
    chk("mrst.count2", 32'(buf_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
